// File: rtl/piece_geom_pkg.sv
// Board geometry shared by the stone disc mask logic.
//   SIDE_X_BEGIN / SIDE_Y_BEGIN : pixel position of the row-0 / column-0 intersection
//   GRID_SIZE                   : pixel pitch between intersections
//   RADIUS                      : stone radius in pixels (inclusive)
//   N_CELLS                     : valid cells per axis (indices 0..N_CELLS-1)
//   R2 / R2_IN                  : outer and inner squared radii for the disc and its outline
package piece_geom_pkg;

    localparam int SIDE_X_BEGIN = 102;
    localparam int SIDE_Y_BEGIN = 23;
    localparam int GRID_SIZE    = 31;
    localparam int RADIUS       = 13;
    localparam int N_CELLS      = 15;

    localparam int R2    = RADIUS * RADIUS;
    localparam int R2_IN = (RADIUS - 1) * (RADIUS - 1);

    typedef logic        [9:0]  coord_t;
    typedef logic        [3:0]  cell_t;
    typedef logic signed [11:0] sdelta_t;
    typedef logic        [23:0] dist2_t;

endpackage

// File: rtl/piece_sq_dist.sv
// Squared distance from a scan pixel to the intersection of its board cell.
// Purely combinational.
//   x, y       : scan coordinate
//   row, col   : board cell the pixel falls in (N_CELLS and above = outside board)
//   dist2      : dx*dx + dy*dy, unsigned
//   cell_valid : high when both row and col index a real cell
module piece_sq_dist
    import piece_geom_pkg::*;
(
    input  coord_t x,
    input  coord_t y,
    input  cell_t  row,
    input  cell_t  col,
    output dist2_t dist2,
    output logic   cell_valid
);

    logic        [10:0] cx;
    logic        [10:0] cy;
    sdelta_t            dx;
    sdelta_t            dy;
    logic signed [23:0] dx_w;
    logic signed [23:0] dy_w;
    logic signed [23:0] sq_x;
    logic signed [23:0] sq_y;

    // Centres fit in 11 bits even for the out-of-board index 15 (max 567 / 488).
    assign cx = 11'(SIDE_X_BEGIN) + 11'(col) * 11'(GRID_SIZE);
    assign cy = 11'(SIDE_Y_BEGIN) + 11'(row) * 11'(GRID_SIZE);

    // Zero-extend both operands to 12 bits before subtracting so a pixel left of
    // or above the centre gives a true negative delta instead of wrapping.
    assign dx = sdelta_t'({2'b00, x}) - sdelta_t'({1'b0, cx});
    assign dy = sdelta_t'({2'b00, y}) - sdelta_t'({1'b0, cy});

    assign dx_w = 24'(dx);
    assign dy_w = 24'(dy);
    assign sq_x = dx_w * dx_w;
    assign sq_y = dy_w * dy_w;

    // Squares are non-negative and their sum stays below 2^21, so the unsigned
    // view of the signed products is exact.
    assign dist2 = dist2_t'(sq_x) + dist2_t'(sq_y);

    assign cell_valid = (row < cell_t'(N_CELLS)) && (col < cell_t'(N_CELLS));

endmodule

// File: rtl/piece_disc_mask.sv
// Registered per-pixel stone disc mask for the 15x15 board display.
// The renderer ANDs judge with the occupancy bits to paint stones.
//   clk   : pixel clock
//   rst   : asynchronous, active-high reset
//   x, y  : current scan coordinate
//   row   : cell row (15 = outside board)
//   col   : cell column (15 = outside board)
//   judge : pixel inside the stone disc, one cycle after the inputs
//   ring  : pixel on the 1-2 px outline of the disc (only when PIECE_DISC_RING_EN is defined)
// Build option: define PIECE_DISC_RING_EN to add the ring output.
module piece_disc_mask
    import piece_geom_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  coord_t x,
    input  coord_t y,
    input  cell_t  row,
    input  cell_t  col,
`ifdef PIECE_DISC_RING_EN
    output logic   ring,
`endif
    output logic   judge
);

    dist2_t dist2;
    logic   cell_valid;
    logic   inside_d;
    logic   judge_q;

    piece_sq_dist u_sq_dist (
        .x          (x),
        .y          (y),
        .row        (row),
        .col        (col),
        .dist2      (dist2),
        .cell_valid (cell_valid)
    );

    assign inside_d = cell_valid && (dist2 <= dist2_t'(R2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            judge_q <= 1'b0;
        end else begin
            judge_q <= inside_d;
        end
    end

    assign judge = judge_q;

`ifdef PIECE_DISC_RING_EN
    logic ring_d;
    logic ring_q;

    // Outline band: inside the disc but not strictly inside the (RADIUS-1) circle.
    assign ring_d = inside_d && (dist2 >= dist2_t'(R2_IN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_q <= 1'b0;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring = ring_q;
`endif

endmodule

// File: tb/tb_piece_disc_mask.sv
module tb_piece_disc_mask;

    logic       clk;
    logic       rst;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] row;
    logic [3:0] col;
    logic       judge;
`ifdef PIECE_DISC_RING_EN
    logic       ring;
`endif

    int n_checks;
    int n_errors;

    piece_disc_mask dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .row   (row),
        .col   (col),
`ifdef PIECE_DISC_RING_EN
        .ring  (ring),
`endif
        .judge (judge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive a pixel at a falling edge, let one rising edge register it, then
    // check judge at the next falling edge.
    task automatic probe(input string tag, input int px, input int py,
                         input int r, input int c, input logic exp_judge);
        @(negedge clk);
        x   = 10'(px);
        y   = 10'(py);
        row = 4'(r);
        col = 4'(c);
        @(negedge clk);
        chk(tag, judge, exp_judge);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        x   = 10'd102;
        y   = 10'd23;
        row = 4'd0;
        col = 4'd0;

        // Reset holds judge low even with an inside pixel on the inputs.
        repeat (2) @(negedge clk);
        chk("reset_judge", judge, 1'b0);
`ifdef PIECE_DISC_RING_EN
        chk("reset_ring", ring, 1'b0);
`endif
        rst = 1'b0;

        // Axis boundary around cell (0,0), centre (102,23).
        probe("centre_00",    102, 23, 0, 0, 1'b1);
        probe("dx_p13",       115, 23, 0, 0, 1'b1);
        probe("dx_p14",       116, 23, 0, 0, 1'b0);
        probe("dy_p13",       102, 36, 0, 0, 1'b1);
        probe("dy_p14",       102, 37, 0, 0, 1'b0);
        probe("dx_m13",        89, 23, 0, 0, 1'b1);

        // Diagonals: 81+81=162 in, 100+81=181 out, 49+49=98 in, 169+169=338 out.
        probe("diag_162",     111, 32, 0, 0, 1'b1);
        probe("diag_181",     112, 32, 0, 0, 1'b0);
        probe("diag_neg_98",   95, 16, 0, 0, 1'b1);
        probe("diag_neg_338",  89, 10, 0, 0, 1'b0);

        // Far corner cell (14,14), centre (536,457).
        probe("corner_centre", 536, 457, 14, 14, 1'b1);
        probe("corner_dy14",   536, 471, 14, 14, 1'b0);

        // Invalid cells and large negative delta.
        probe("row15",         195, 23, 15, 3, 1'b0);
        probe("col15",         567, 23, 0, 15, 1'b0);
        probe("dx_m102",         0, 23, 0, 0, 1'b0);

        // Latency: new inputs must not show before the next rising edge.
        probe("lat_setup",     102, 23, 0, 0, 1'b1);
        @(negedge clk);
        x = 10'd200;
        #1;
        chk("lat_hold", judge, 1'b1);
        @(negedge clk);
        chk("lat_update", judge, 1'b0);

        // Asynchronous reset between edges.
        probe("rst_pre",       102, 23, 0, 0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", judge, 1'b0);
        @(negedge clk);
        chk("rst_held", judge, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release", judge, 1'b1);

        // Cell (7,7), centre (319,240): outline band checks.
        probe("c77_dx13",      332, 240, 7, 7, 1'b1);
`ifdef PIECE_DISC_RING_EN
        chk("ring_dx13", ring, 1'b1);
`endif
        probe("c77_dx6",       325, 240, 7, 7, 1'b1);
`ifdef PIECE_DISC_RING_EN
        chk("ring_dx6", ring, 1'b0);
`endif
        probe("c77_dx14",      333, 240, 7, 7, 1'b0);
`ifdef PIECE_DISC_RING_EN
        chk("ring_dx14", ring, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
